// File: rtl/ysyx_040066_div_issue.sv
// EX-stage issue/collect control for the multi-cycle divider.
// Divide-by-zero is resolved locally; ops flushed while in flight are drained and dropped.
module ysyx_040066_div_issue #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_div,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic            ex_is_w,
  input  logic [1:0]      ex_aluctr,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] div_src1,
  output logic [XLEN-1:0] div_src2,
  output logic            div_is_w,
  output logic [1:0]      div_aluctr,
  output logic            div_in_valid,
  input  logic            div_in_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_result,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd
);

  // state | meaning
  // IDLE  | nothing in flight, accepts a new divide op
  // REQ   | div_in_valid raised, waiting for div_in_ready
  // WAIT  | divider working on our op
  // DONE  | result held, single wb_valid cycle
  // DRAIN | divider working on a flushed op, its result is dropped
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            is_w_q, is_w_d;
  logic [1:0]      aluctr_q, aluctr_d;
  logic [4:0]      rd_q, rd_d;
  logic            ex_req;
  logic            div_by_zero;
  logic [XLEN-1:0] zero_res;

  assign ex_req      = ex_valid & ex_is_div & ~flush;
  assign div_by_zero = ex_is_w ? (ex_src2[31:0] == 32'd0) : (ex_src2 == '0);
  // W sign-extension of the remainder is applied on the writeback path
  assign zero_res    = ex_aluctr[1] ? ex_src1 : '1;

  always_comb begin
    state_d      = state_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    is_w_d       = is_w_q;
    aluctr_d     = aluctr_q;
    rd_d         = rd_q;
    res_d        = res_q;
    stall        = 1'b0;
    div_in_valid = 1'b0;
    wb_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = ex_req;
        if (ex_req) begin
          src1_d   = ex_src1;
          src2_d   = ex_src2;
          is_w_d   = ex_is_w;
          aluctr_d = ex_aluctr;
          rd_d     = ex_rd;
          if (div_by_zero) begin
            res_d   = zero_res;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall        = 1'b1;
        div_in_valid = 1'b1;
        if (flush) begin
          state_d = div_in_ready ? S_DRAIN : S_IDLE;
        end else if (div_in_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (div_out_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            res_d   = div_result;
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        wb_valid = ~flush;
        state_d  = S_IDLE;
      end
      S_DRAIN: begin
        // divider cannot be aborted: hold any new op until the stale result passes
        stall = ex_req;
        if (div_out_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      is_w_q   <= 1'b0;
      aluctr_q <= 2'b00;
      rd_q     <= 5'd0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      is_w_q   <= is_w_d;
      aluctr_q <= aluctr_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
    end
  end

  assign div_src1   = src1_q;
  assign div_src2   = src2_q;
  assign div_is_w   = is_w_q;
  assign div_aluctr = aluctr_q;
  assign wb_data    = is_w_q ? {{(XLEN-32){res_q[31]}}, res_q[31:0]} : res_q;
  assign wb_rd      = rd_q;

endmodule

// File: tb/tb_ysyx_040066_div_issue.sv
// Bench for ysyx_040066_div_issue: behavioural divider + RISC-V arithmetic reference model,
// per-cycle writeback scoreboard and directed scenarios with literal expectations.
module tb_ysyx_040066_div_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid, ex_is_div, ex_is_w, flush;
  logic [63:0] ex_src1, ex_src2;
  logic [1:0]  ex_aluctr;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [63:0] div_src1, div_src2;
  logic        div_is_w;
  logic [1:0]  div_aluctr;
  logic        div_in_valid, div_in_ready, div_out_valid;
  logic [63:0] div_result;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  ysyx_040066_div_issue dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_div(ex_is_div), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_is_w(ex_is_w), .ex_aluctr(ex_aluctr), .ex_rd(ex_rd), .flush(flush),
    .stall(stall), .div_src1(div_src1), .div_src2(div_src2), .div_is_w(div_is_w),
    .div_aluctr(div_aluctr), .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
    .div_out_valid(div_out_valid), .div_result(div_result),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int vld_cycles = 0;
  int wb_count = 0;
  logic [63:0] last_wb_data = '0;
  logic [4:0]  last_wb_rd = '0;
  logic [68:0] exp_q[$];

  // divider model state
  int          dlat = 3;
  bit          hold_rdy = 1'b0;
  bit          busy = 1'b0;
  int          cnt = 0;
  bit          hs_pend = 1'b0;
  logic [63:0] pend_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics, written straight from the ISA rules
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic w, input logic [1:0] c);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] r32;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    if (w) begin
      if (b[31:0] == 32'd0) r32 = c[1] ? a[31:0] : 32'hFFFF_FFFF;
      else if (c[0]) r32 = c[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = c[1] ? 32'd0 : 32'h8000_0000;
      else r32 = c[1] ? sa32 % sb32 : sa32 / sb32;
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) r = c[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (c[0]) r = c[1] ? a % b : a / b;
      else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = c[1] ? 64'd0 : a;
      else r = c[1] ? sa % sb : sa / sb;
    end
    return r;
  endfunction

  // Divider: accepts on valid&ready, pulses out_valid dlat cycles later.
  // W results carry junk in the upper half so the DUT must sign-extend.
  initial begin
    div_in_ready = 1'b1; div_out_valid = 1'b0; div_result = '0;
    forever begin
      @(negedge clk);
      hs_pend = rst && div_in_valid && div_in_ready;
      if (hs_pend) begin
        pend_res = ref_div(div_src1, div_src2, div_is_w, div_aluctr);
        if (div_is_w) pend_res = {32'hDEAD_BEEF, pend_res[31:0]};
      end
      @(posedge clk); #1;
      div_out_valid = 1'b0;
      if (!rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          if (cnt == 0) begin
            div_out_valid = 1'b1; div_result = pend_res; busy = 1'b0;
          end else cnt--;
        end
        if (hs_pend) begin busy = 1'b1; cnt = dlat - 1; end
      end
      div_in_ready = !busy && !hold_rdy;
    end
  end

  // Per-cycle compare: writeback scoreboard and request-stability monitor
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [63:0] prev_s1, prev_s2;
  logic [2:0]  prev_ctl;
  always @(negedge clk) begin
    logic [68:0] e;
    if (rst) begin
      if (div_in_valid) vld_cycles++;
      if (div_in_valid && div_in_ready) hs_count++;
      if (prev_v && !prev_r && div_in_valid) begin
        chk("req_src1_stable", div_src1, prev_s1);
        chk("req_src2_stable", div_src2, prev_s2);
        chk("req_ctl_stable", {61'd0, div_is_w, div_aluctr}, {61'd0, prev_ctl});
      end
      if (wb_valid) begin
        wb_count++;
        last_wb_data = wb_data;
        last_wb_rd = wb_rd;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_wb: got wb_valid data %h rd %0d, required no writeback", wb_data, wb_rd);
        end else begin
          e = exp_q.pop_front();
          chk("wb_data", wb_data, e[63:0]);
          chk("wb_rd", {59'd0, wb_rd}, {59'd0, e[68:64]});
        end
      end
      prev_v = div_in_valid; prev_r = div_in_ready;
      prev_s1 = div_src1; prev_s2 = div_src2; prev_ctl = {div_is_w, div_aluctr};
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic present(input logic [63:0] a, input logic [63:0] b, input logic w,
                         input logic [1:0] c, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_div = 1'b1; ex_src1 = a; ex_src2 = b;
    ex_is_w = w; ex_aluctr = c; ex_rd = rd;
  endtask

  // Issue one op expected to write back; returns negedges from presentation to stall release.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic w,
                        input logic [1:0] c, input logic [4:0] rd, output int cyc);
    @(posedge clk); #1;
    present(a, b, w, c, rd);
    exp_q.push_back({rd, ref_div(a, b, w, c)});
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (stall && cyc < 200);
    checks++;
    if (stall) begin
      failures++;
      $display("FAIL op_timeout: stall still %b after %0d cycles, required 0", stall, cyc);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_is_div = 1'b0;
  endtask

  task automatic wait_hs();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(div_in_valid && div_in_ready) && n < 100);
    checks++;
    if (!(div_in_valid && div_in_ready)) begin
      failures++;
      $display("FAIL hs_timeout: no divider handshake in %0d cycles, required one", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, v0, h0, w0;
    ex_valid = 1'b0; ex_is_div = 1'b0; ex_src1 = '0; ex_src2 = '0;
    ex_is_w = 1'b0; ex_aluctr = 2'b00; ex_rd = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_in_valid", {63'd0, div_in_valid}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_div_src1", div_src1, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // pin the reference model itself
    chk("pin_div", ref_div(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 2'b00), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_divw_ovf", ref_div(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b00), 64'hFFFF_FFFF_8000_0000);
    chk("pin_remu", ref_div(64'd100, 64'd7, 1'b0, 2'b11), 64'd2);

    // normal ops
    dlat = 3;
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 2'b00, 5'd1, cyc); idle();
    chk("div_latency", 64'(cyc), 64'd7);
    chk("lit_div", last_wb_data, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 2'b10, 5'd2, cyc); idle();
    chk("lit_rem", last_wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h0000_0000_FFFF_FFFE, 64'd2, 1'b1, 2'b01, 5'd3, cyc); idle();
    chk("lit_divuw", last_wb_data, 64'h0000_0000_7FFF_FFFF);
    run_op(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b00, 5'd4, cyc); idle();
    chk("lit_divw_ovf", last_wb_data, 64'hFFFF_FFFF_8000_0000);
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00, 5'd5, cyc); idle();
    chk("lit_div_ovf", last_wb_data, 64'h8000_0000_0000_0000);
    run_op(64'd100, 64'd7, 1'b0, 2'b01, 5'd6, cyc); idle();
    chk("lit_divu", last_wb_data, 64'd14);

    // divide by zero: resolved locally, one cycle after acceptance
    v0 = vld_cycles;
    run_op(64'h1234, 64'd0, 1'b0, 2'b00, 5'd10, cyc); idle();
    chk("dz_latency", 64'(cyc), 64'd2);
    chk("lit_dz_div", last_wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h8000_0000, 64'h1_0000_0000, 1'b1, 2'b10, 5'd11, cyc); idle();
    chk("lit_dz_remw", last_wb_data, 64'hFFFF_FFFF_8000_0000);
    chk("dz_no_req", 64'(vld_cycles), 64'(v0));

    // flush on the DONE cycle suppresses writeback
    @(posedge clk); #1;
    present(64'd5, 64'd0, 1'b0, 2'b00, 5'd12);
    @(negedge clk);
    chk("dz_accept_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_done_wb", {63'd0, wb_valid}, 64'd0);
    @(posedge clk); #1 flush = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0;

    // divider not ready for 5 cycles, then flush in REQ
    @(posedge clk); #1 hold_rdy = 1'b1;
    @(posedge clk); #1;
    present(64'h5555_AAAA_0000_1111, 64'd3, 1'b0, 2'b01, 5'd13);
    h0 = hs_count;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_valid", {63'd0, div_in_valid}, 64'd1);
      chk("hold_src1", div_src1, 64'h5555_AAAA_0000_1111);
      chk("hold_stall", {63'd0, stall}, 64'd1);
    end
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 flush = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0; hold_rdy = 1'b0;
    @(negedge clk);
    chk("req_flush_in_valid", {63'd0, div_in_valid}, 64'd0);
    chk("req_flush_stall", {63'd0, stall}, 64'd0);
    repeat (5) @(negedge clk);
    chk("req_flush_no_hs", 64'(hs_count), 64'(h0));

    // flush in WAIT: drain, hold the next op, then issue it
    dlat = 20;
    @(posedge clk); #1;
    present(64'd1000, 64'd10, 1'b0, 2'b00, 5'd14);
    wait_hs();
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("wait_flush_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1 flush = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0;
    @(negedge clk);
    chk("drain_stall_drop", {63'd0, stall}, 64'd0);
    v0 = vld_cycles;
    run_op(64'd77, 64'd5, 1'b0, 2'b11, 5'd15, cyc); idle();
    chk("drain_held_latency", 64'(cyc), 64'd34);
    chk("drain_one_req", 64'(vld_cycles - v0), 64'd1);
    chk("lit_after_drain", last_wb_data, 64'd2);

    // async reset while waiting on the divider
    dlat = 8;
    @(posedge clk); #1;
    present(64'd81, 64'd9, 1'b0, 2'b00, 5'd16);
    wait_hs();
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_stall", {63'd0, stall}, 64'd1);
    rst = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0;
    #1;
    chk("rst_async_stall", {63'd0, stall}, 64'd0);
    chk("rst_async_in_valid", {63'd0, div_in_valid}, 64'd0);
    chk("rst_async_wb_valid", {63'd0, wb_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // back-to-back after reset
    dlat = 2;
    w0 = wb_count;
    run_op(64'd50, 64'd7, 1'b0, 2'b00, 5'd7, cyc);
    run_op(64'hFFFF_FFFF_FFFF_FFCE, 64'd7, 1'b0, 2'b10, 5'd8, cyc);
    run_op(64'h0000_0001_0000_0009, 64'd4, 1'b1, 2'b01, 5'd9, cyc);
    idle();
    repeat (3) @(negedge clk);
    chk("b2b_wb_count", 64'(wb_count - w0), 64'd3);
    chk("b2b_last_rd", {59'd0, last_wb_rd}, 64'd9);
    chk("b2b_last_data", last_wb_data, 64'd2);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
